// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: synchronises rx_i, samples each bit at mid-period,
// checks the stop bit and hands each byte over on a valid/ready handshake.
module uart_rx #(
  parameter int CLK_PER_BIT = 10416,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic [2:0]             idx;
  logic [7:0]             shreg;
  logic                   rxs;

  assign rxs = sync_q[SYNC_STAGES-1];

  // NOTE: reset is synchronous and active-high, so it lives inside the clocked
  // branch; the synchroniser resets to 1 so an idle line is not seen as a start bit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      sync_q      <= '1;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      rx_data_o   <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rx_i};
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      // NOTE: non-blocking assignments make the later delivery below override this
      // clear, so an accept and a new byte in the same cycle keep valid_o high.
      if (valid_o && ready_i) valid_o <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (!rxs) begin
            state <= S_START;
            cnt   <= '0;
          end
        end

        S_START: begin
          if (cnt == HALF_CNT) begin
            cnt <= '0;
            if (!rxs) begin
              state <= S_DATA;
              idx   <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == LAST_CNT) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == 3'd7) state <= S_STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (rxs) begin
              // Returning to IDLE at mid stop bit lets a back-to-back start edge be caught.
              state <= S_IDLE;
              if (!valid_o || ready_i) begin
                rx_data_o <= shreg;
                valid_o   <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              frame_err_o <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BREAK: begin
          if (rxs) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
